// File: rtl/evm_pkg.sv
// Shared definitions for the N-candidate EVM: state codes and small vote helpers.
// Pure declarations, no timing; imported by the controller and the winner scan.
package evm_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_CAND = 3'd1;
  localparam state_t ST_WAIT_VOTE = 3'd2;
  localparam state_t ST_VOTED     = 3'd3;
  localparam state_t ST_TALLY     = 3'd4;
  localparam state_t ST_DONE      = 3'd5;

  // Widest vote vector supported (NUM_CAND <= 15 fits with room to spare).
  localparam int MAX_CAND = 16;

  function automatic logic is_onehot(input logic [MAX_CAND-1:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

  function automatic logic [4:0] name_of(input logic [3:0] idx);
    return {1'b0, idx} + 5'd1;
  endfunction

endpackage

// File: rtl/evm_winner_scan.sv
// Sequential arg-max over the vote counters, one index per cycle.
// Start pulse begins a scan of exactly NUM_CAND cycles; o_done marks the last one.
module evm_winner_scan
  import evm_pkg::*;
#(
  parameter int NUM_CAND = 8,
  parameter int WIDTH    = 8,
  parameter int IW       = $clog2(NUM_CAND)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_val,
  output logic [IW-1:0]    o_idx,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_max,
  output logic [IW-1:0]    o_win,
  output logic             o_tie
);

  logic [IW-1:0]    r_idx;
  logic             r_busy;
  logic [WIDTH-1:0] r_max;
  logic [IW-1:0]    r_win;
  logic             r_tie;

  assign o_idx  = r_idx;
  assign o_busy = r_busy;
  assign o_done = r_busy && (r_idx == IW'(NUM_CAND - 1));
  assign o_max  = r_max;
  assign o_win  = r_win;
  assign o_tie  = r_tie;

  // Max starts at 0, so an all-zero tally ends with the tie flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_busy <= 1'b0;
      r_max  <= '0;
      r_win  <= '0;
      r_tie  <= 1'b0;
    end else if (i_clear || i_start) begin
      r_idx  <= '0;
      r_busy <= i_start && !i_clear;
      r_max  <= '0;
      r_win  <= '0;
      r_tie  <= 1'b0;
    end else if (r_busy) begin
      if (i_val > r_max) begin
        r_max <= i_val;
        r_win <= r_idx;
        r_tie <= 1'b0;
      end else if (i_val == r_max) begin
        r_tie <= 1'b1;
      end
      if (o_done) r_busy <= 1'b0;
      else        r_idx  <= r_idx + IW'(1);
    end
  end

endmodule

// File: rtl/evm_multi.sv
// N-candidate EVM controller: vote FSM, idle timer, saturating counters, result display.
// Votes register one cycle after acceptance; tally takes NUM_CAND cycles before DONE.
module evm_multi
  import evm_pkg::*;
#(
  parameter  int NUM_CAND = 8,
  parameter  int WIDTH    = 8,
  parameter  int TIMEOUT  = 100,
  localparam int IW       = $clog2(NUM_CAND),
  localparam int NW       = $clog2(NUM_CAND + 1),
  localparam int TW       = $clog2(TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_switch_on_evm,
  input  logic                i_candidate_ready,
  input  logic [NUM_CAND-1:0] i_vote,
  input  logic                i_voting_session_done,
  input  logic [IW-1:0]       i_display_sel,
  input  logic                i_display_winner,
  output logic [NW-1:0]       o_candidate_name,
  output logic [WIDTH-1:0]    o_results,
  output logic                o_invalid_results,
  output logic                o_voting_in_progress,
  output logic                o_voting_done,
  output logic                o_tally_busy,
  output logic                o_vote_rejected,
  output logic                o_overflow
);

  state_t           r_state;
  state_t           w_next;
  logic [TW-1:0]    r_timer;
  logic [WIDTH-1:0] r_count [NUM_CAND];
  logic [IW-1:0]    r_sel;
  logic             r_overflow;

  logic             w_onehot, w_multi, w_accept, w_tmo, w_wait, w_start;
  logic [IW-1:0]    w_vote_idx;
  logic [IW-1:0]    w_scan_idx, w_win;
  logic             w_scan_busy, w_scan_done, w_tie;
  logic [WIDTH-1:0] w_scan_val, w_max;

  assign w_onehot = is_onehot(MAX_CAND'(i_vote));
  assign w_multi  = (i_vote != '0) && !w_onehot;
  assign w_accept = w_onehot && !i_candidate_ready;
  assign w_tmo    = (r_timer == TW'(TIMEOUT));
  assign w_wait   = (r_state == ST_WAIT_CAND) || (r_state == ST_WAIT_VOTE);

  always_comb begin
    w_vote_idx = '0;
    for (int i = 0; i < NUM_CAND; i++)
      if (i_vote[i]) w_vote_idx = IW'(i);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      w_next = ST_WAIT_CAND;
      ST_WAIT_CAND: if (i_candidate_ready)          w_next = ST_WAIT_VOTE;
                    else if (i_voting_session_done) w_next = ST_TALLY;
                    else if (w_tmo)                 w_next = ST_TALLY;
      ST_WAIT_VOTE: if (w_accept)                   w_next = ST_VOTED;
                    else if (!w_multi && w_tmo)     w_next = ST_WAIT_CAND;
      ST_VOTED:     w_next = i_candidate_ready ? ST_WAIT_VOTE : ST_WAIT_CAND;
      ST_TALLY:     if (w_scan_done)                w_next = ST_DONE;
      ST_DONE:      w_next = ST_DONE;
      default:      w_next = ST_IDLE;
    endcase
    if (!i_switch_on_evm) w_next = ST_IDLE;
  end

  assign w_start = (w_next == ST_TALLY) && (r_state != ST_TALLY);

  // Every state change clears the timer; it saturates so a late multi-hot cannot wrap it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)   r_timer <= '0;
      else if (w_wait && !w_tmo) r_timer <= r_timer + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CAND; i++) r_count[i] <= '0;
      r_sel      <= '0;
      r_overflow <= 1'b0;
    end else if (!i_switch_on_evm) begin
      for (int i = 0; i < NUM_CAND; i++) r_count[i] <= '0;
      r_sel      <= '0;
      r_overflow <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      for (int i = 0; i < NUM_CAND; i++) r_count[i] <= '0;
    end else begin
      if (r_state == ST_WAIT_VOTE && w_accept) r_sel <= w_vote_idx;
      if (r_state == ST_VOTED) begin
        if (r_count[r_sel] == '1) r_overflow <= 1'b1;
        else                      r_count[r_sel] <= r_count[r_sel] + WIDTH'(1);
      end
    end
  end

  assign w_scan_val = w_scan_busy ? r_count[w_scan_idx] : '0;

  evm_winner_scan #(
    .NUM_CAND (NUM_CAND),
    .WIDTH    (WIDTH),
    .IW       (IW)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .i_clear (!i_switch_on_evm),
    .i_start (w_start),
    .i_val   (w_scan_val),
    .o_idx   (w_scan_idx),
    .o_busy  (w_scan_busy),
    .o_done  (w_scan_done),
    .o_max   (w_max),
    .o_win   (w_win),
    .o_tie   (w_tie)
  );

  always_comb begin
    o_candidate_name  = '0;
    o_results         = '0;
    o_invalid_results = 1'b0;
    if (r_state == ST_DONE) begin
      o_invalid_results = w_tie;
      if (i_display_winner) begin
        if (!w_tie) begin
          o_candidate_name = NW'(name_of(4'(w_win)));
          o_results        = w_max;
        end
      end else if (NW'(i_display_sel) < NW'(NUM_CAND)) begin
        o_candidate_name = NW'(name_of(4'(i_display_sel)));
        o_results        = r_count[i_display_sel];
      end
    end
  end

  assign o_voting_in_progress = (r_state == ST_WAIT_VOTE);
  assign o_voting_done        = (r_state == ST_DONE);
  assign o_tally_busy         = (r_state == ST_TALLY);
  assign o_vote_rejected      = i_switch_on_evm && (r_state == ST_WAIT_VOTE) && w_multi;
  assign o_overflow           = r_overflow;

endmodule

// File: tb/tb_evm_multi.sv
// Randomized and directed bench for evm_multi (4 candidates, 3-bit counters, timeout 4).
// Expected tallies come from a per-candidate count array and a two-pass max search.
module tb_evm_multi;

  localparam int NC = 4;
  localparam int W  = 3;
  localparam int TO = 4;
  localparam int CMAX = (1 << W) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw, ready, sdone, dwin;
  logic [3:0] vote;
  logic [1:0] sel;
  logic [2:0] name;
  logic [2:0] res;
  logic       inv, vip, vdone, busy, rej, ovf;

  int n_checks = 0;
  int n_errors = 0;
  int m_count [NC];
  bit m_ovf;

  always #5 clk = ~clk;

  evm_multi #(.NUM_CAND(NC), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_switch_on_evm       (sw),
    .i_candidate_ready     (ready),
    .i_vote                (vote),
    .i_voting_session_done (sdone),
    .i_display_sel         (sel),
    .i_display_winner      (dwin),
    .o_candidate_name      (name),
    .o_results             (res),
    .o_invalid_results     (inv),
    .o_voting_in_progress  (vip),
    .o_voting_done         (vdone),
    .o_tally_busy          (busy),
    .o_vote_rejected       (rej),
    .o_overflow            (ovf)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic power_off();
    sw = 1'b0;
    step();
    foreach (m_count[i]) m_count[i] = 0;
    m_ovf = 1'b0;
  endtask

  task automatic power_on();
    sw = 1'b1;
    step();
    foreach (m_count[i]) m_count[i] = 0;
  endtask

  // One voter: arrive, optionally press two buttons first, then a single valid vote.
  task automatic cast(input int c, input bit try_multi);
    int a, b;
    ready = 1'b1;
    step();
    ready = 1'b0;
    #1 chk_eq("vote_in_progress", 32'(vip), 1);
    if (try_multi) begin
      a = $urandom_range(0, NC - 1);
      b = (a + 1 + $urandom_range(0, NC - 2)) % NC;
      vote = 4'((1 << a) | (1 << b));
      #1 chk_eq("multi_rejected", 32'(rej), 1);
      step();
      vote = '0;
      #1 chk_eq("reject_one_cycle", 32'(rej), 0);
      chk_eq("stay_after_reject", 32'(vip), 1);
    end
    vote = 4'(1 << c);
    step();
    vote = '0;
    #1 chk_eq("left_wait_vote", 32'(vip), 0);
    step();
    if (m_count[c] == CMAX) m_ovf = 1'b1;
    else                    m_count[c]++;
    #1 chk_eq("overflow_flag", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic wait_tally(input string tag);
    int n;
    n = 0;
    #1;
    while (busy === 1'b1 && n < 20) begin
      n++;
      step();
      #1;
    end
    chk_eq({tag, ".tally_cycles"}, n, NC);
    chk_eq({tag, ".voting_done"}, 32'(vdone), 1);
  endtask

  task automatic close_session(input string tag);
    sdone = 1'b1;
    step();
    sdone = 1'b0;
    wait_tally(tag);
  endtask

  task automatic check_display(input string tag);
    int mx, nmx, wi;
    bit bad;
    mx = 0;
    foreach (m_count[i]) if (m_count[i] > mx) mx = m_count[i];
    nmx = 0;
    wi  = 0;
    foreach (m_count[i]) if (m_count[i] == mx) begin nmx++; wi = i; end
    bad = (nmx != 1);
    dwin = 1'b1;
    #1;
    chk_eq({tag, ".invalid"},  32'(inv),  32'(bad));
    chk_eq({tag, ".win_name"}, 32'(name), bad ? 0 : wi + 1);
    chk_eq({tag, ".win_res"},  32'(res),  bad ? 0 : mx);
    dwin = 1'b0;
    for (int s = 0; s < NC; s++) begin
      sel = 2'(s);
      #1;
      chk_eq($sformatf("%s.sel%0d_name", tag, s), 32'(name), s + 1);
      chk_eq($sformatf("%s.sel%0d_res", tag, s),  32'(res),  m_count[s]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    rst = 1'b1; sw = 1'b0; ready = 1'b0; sdone = 1'b0; dwin = 1'b0;
    vote = '0; sel = '0;
    foreach (m_count[i]) m_count[i] = 0;
    m_ovf = 1'b0;
    step(); step();
    chk_eq("rst.name",  32'(name),  0);
    chk_eq("rst.res",   32'(res),   0);
    chk_eq("rst.inv",   32'(inv),   0);
    chk_eq("rst.vip",   32'(vip),   0);
    chk_eq("rst.vdone", 32'(vdone), 0);
    chk_eq("rst.busy",  32'(busy),  0);
    chk_eq("rst.rej",   32'(rej),   0);
    chk_eq("rst.ovf",   32'(ovf),   0);
    rst = 1'b0;
    step();

    // Plain election 3/0/1/2.
    power_on();
    cast(0, 0); cast(0, 0); cast(0, 0); cast(2, 0); cast(3, 0); cast(3, 0);
    chk_eq("outside_done.name", 32'(name), 0);
    close_session("basic");
    check_display("basic");
    power_off();

    // Multi-hot rejection and one-hot ignored while the voter is still flagged ready.
    power_on();
    ready = 1'b1;
    step();
    vote = 4'b0001;
    step();
    #1 chk_eq("onehot_ignored_ready", 32'(vip), 1);
    ready = 1'b0;
    vote  = 4'b0110;
    #1 chk_eq("reject_0110", 32'(rej), 1);
    step();
    vote = 4'b0000;
    #1 chk_eq("reject_cleared", 32'(rej), 0);
    vote = 4'b0100;
    step();
    vote = '0;
    step();
    m_count[2] = 1;
    close_session("reject");
    check_display("reject");
    power_off();

    // Abandoned voter then idle booth: both waits exit after TIMEOUT+1 cycles.
    power_on();
    ready = 1'b1;
    step();
    ready = 1'b0;
    n = 0;
    #1;
    while (vip === 1'b1 && n < 20) begin n++; step(); #1; end
    chk_eq("wait_vote_timeout", n, TO + 1);
    n = 0;
    while (busy !== 1'b1 && n < 20) begin n++; step(); #1; end
    chk_eq("wait_cand_timeout", n, TO + 1);
    wait_tally("timeout");
    check_display("timeout");
    power_off();

    // Saturation at 7 with sticky overflow.
    power_on();
    for (int i = 0; i < 8; i++) cast(1, 0);
    close_session("ovf");
    check_display("ovf");
    chk_eq("ovf.sticky", 32'(ovf), 1);
    power_off();

    // Tie 2/2/1/0.
    power_on();
    cast(0, 0); cast(1, 0); cast(0, 0); cast(1, 0); cast(2, 0);
    close_session("tie");
    check_display("tie");
    power_off();

    // Power switch dropped in the middle of a tally.
    power_on();
    for (int i = 0; i < 8; i++) cast(3, 0);
    sdone = 1'b1;
    step();
    sdone = 1'b0;
    step();
    #1 chk_eq("midtally.busy", 32'(busy), 1);
    power_off();
    #1;
    chk_eq("midtally.busy_off", 32'(busy), 0);
    chk_eq("midtally.ovf_off",  32'(ovf),  0);
    chk_eq("midtally.vdone",    32'(vdone), 0);
    power_on();
    close_session("after_off");
    check_display("after_off");
    power_off();

    // Random elections.
    for (int r = 0; r < 4; r++) begin
      power_on();
      k = $urandom_range(3, 12);
      for (int v = 0; v < k; v++)
        cast($urandom_range(0, NC - 1), ($urandom_range(0, 3) == 0));
      close_session($sformatf("rand%0d", r));
      check_display($sformatf("rand%0d", r));
      power_off();
    end

    // Asynchronous reset clears the display mid-cycle.
    power_on();
    cast(2, 0);
    close_session("arst");
    dwin = 1'b0;
    sel  = 2'd2;
    #1 chk_eq("arst.before", 32'(name), 3);
    rst = 1'b1;
    #1;
    chk_eq("arst.name",  32'(name),  0);
    chk_eq("arst.res",   32'(res),   0);
    chk_eq("arst.vdone", 32'(vdone), 0);
    step();
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
